// File: rtl/led_pattern_gen.sv
// Eight-LED pattern generator: debounced mode/pause buttons drive a four-mode pattern FSM.
// Optional PWM dimming of the LED outputs is compiled in when LED_PWM_EN is defined.
module led_pattern_gen #(
  parameter int unsigned TICK_DIV   = 1200000,
  parameter int unsigned DEB_CYCLES = 120000,
  parameter logic [7:0]  PWM_DUTY   = 8'd64
) (
  input  logic CLK,
  input  logic RST,
  input  logic SW1,
  input  logic SW2,
  output logic LED0,
  output logic LED1,
  output logic LED2,
  output logic LED3,
  output logic LED4,
  output logic LED5,
  output logic LED6,
  output logic LED7
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TickLast = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DebLast  = DW'(DEB_CYCLES - 1);

  localparam logic [1:0] ModeShift  = 2'd0;
  localparam logic [1:0] ModeBounce = 2'd1;
  localparam logic [1:0] ModeCount  = 2'd2;
  localparam logic [1:0] ModeBlink  = 2'd3;

  // Index 0 is SW1 (mode), index 1 is SW2 (pause).
  logic [1:0]    sw_raw;
  logic [1:0]    sync1_q, sync2_q, stable_q, press;
  logic [DW-1:0] deb_cnt_q [2];

  assign sw_raw = {SW2, SW1};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stable_q <= '0;
      for (int i = 0; i < 2; i++) deb_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == stable_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DebLast) begin
          deb_cnt_q[i] <= '0;
          stable_q[i]  <= sync2_q[i];
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Pulse coincides with the edge that flips the stable level from 0 to 1.
  assign press[0] = sync2_q[0] & ~stable_q[0] & (deb_cnt_q[0] == DebLast);
  assign press[1] = sync2_q[1] & ~stable_q[1] & (deb_cnt_q[1] == DebLast);

  function automatic logic [7:0] init_pattern(input logic [1:0] m);
    unique case (m)
      ModeCount: return 8'h00;
      ModeBlink: return 8'h55;
      default:   return 8'h01;
    endcase
  endfunction

  logic [1:0]    mode_q, mode_d;
  logic [7:0]    pattern_q, pattern_d;
  logic          dir_up_q, dir_up_d;
  logic          paused_q, paused_d;
  logic [TW-1:0] presc_q, presc_d;
  logic          tick;

  assign tick = ~paused_q & (presc_q == TickLast);

  always_comb begin
    mode_d    = mode_q;
    pattern_d = pattern_q;
    dir_up_d  = dir_up_q;
    presc_d   = presc_q;
    paused_d  = paused_q ^ press[1];
    if (press[0]) begin
      // A mode load wins over a coincident tick, paused or not.
      mode_d    = mode_q + 2'd1;
      pattern_d = init_pattern(mode_d);
      dir_up_d  = 1'b1;
      presc_d   = '0;
    end else if (!paused_q) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        unique case (mode_q)
          ModeShift: pattern_d = {pattern_q[6:0], pattern_q[7]};
          ModeBounce: begin
            if (dir_up_q) begin
              if (pattern_q == 8'h80) begin
                pattern_d = 8'h40;
                dir_up_d  = 1'b0;
              end else begin
                pattern_d = pattern_q << 1;
              end
            end else begin
              if (pattern_q == 8'h01) begin
                pattern_d = 8'h02;
                dir_up_d  = 1'b1;
              end else begin
                pattern_d = pattern_q >> 1;
              end
            end
          end
          ModeCount: pattern_d = pattern_q + 8'd1;
          ModeBlink: pattern_d = ~pattern_q;
          default:   pattern_d = pattern_q;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode_q    <= ModeShift;
      pattern_q <= 8'h01;
      dir_up_q  <= 1'b1;
      paused_q  <= 1'b0;
      presc_q   <= '0;
    end else begin
      mode_q    <= mode_d;
      pattern_q <= pattern_d;
      dir_up_q  <= dir_up_d;
      paused_q  <= paused_d;
      presc_q   <= presc_d;
    end
  end

  logic [7:0] led;

`ifdef LED_PWM_EN
  logic [7:0] pwm_cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) pwm_cnt_q <= 8'd0;
    else     pwm_cnt_q <= pwm_cnt_q + 8'd1;
  end

  assign led = pattern_q & {8{pwm_cnt_q < PWM_DUTY}};
`else
  logic unused_pwm_duty;
  assign unused_pwm_duty = ^PWM_DUTY;
  assign led = pattern_q;
`endif

  assign LED0 = led[0];
  assign LED1 = led[1];
  assign LED2 = led[2];
  assign LED3 = led[3];
  assign LED4 = led[4];
  assign LED5 = led[5];
  assign LED6 = led[6];
  assign LED7 = led[7];

endmodule
